// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES S-box arithmetic, used by both the forward and the inverse S-box.
//   - AFFINE_C          : additive constant of the AES affine transform (0x63)
//   - *_MAT / *_MAP     : GF(2) 8x8 matrices, entry [i] is the row mask that
//                         produces output bit i (out[i] = parity(row & in))
//   - gf4_* functions   : GF(2^4) arithmetic in the tower representation
//                         GF(((2^2)^2)^2): GF(2^2) mod x^2+x+1, GF(2^4) mod
//                         y^2+y+phi (phi = {10}), GF(2^8) mod z^2+z+lambda
//                         (lambda = {1100}).
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] AFFINE_C   = 8'h63;
    localparam logic [3:0] GF4_LAMBDA = 4'hC;

    // Forward AES affine matrix: out[i] = x[i]^x[i+4]^x[i+5]^x[i+6]^x[i+7]
    localparam logic [7:0][7:0] AFFINE_MAT =
        {8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'h8F, 8'hC7, 8'hE3, 8'hF1};

    // Inverse affine matrix: out[i] = x[i+2]^x[i+5]^x[i+7]
    localparam logic [7:0][7:0] INV_AFFINE_MAT =
        {8'h52, 8'h29, 8'h94, 8'h4A, 8'h25, 8'h92, 8'h49, 8'hA4};

    // GF(2^8) polynomial basis -> composite field {high nibble, low nibble}
    localparam logic [7:0][7:0] ISO_MAP =
        {8'hA0, 8'hDE, 8'hAC, 8'hAE, 8'hC6, 8'h9E, 8'h52, 8'h43};

    // Composite field -> GF(2^8) polynomial basis
    localparam logic [7:0][7:0] INV_ISO_MAP =
        {8'hE2, 8'h44, 8'h62, 8'h76, 8'h3E, 8'h9E, 8'h30, 8'h75};

    function automatic logic [7:0] gf2_mat_mul(input logic [7:0][7:0] m,
                                               input logic [7:0]       x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = ^(m[i] & x);
        end
        return r;
    endfunction

    // GF(2^2) multiply, basis {x, 1}, x^2 = x + 1
    function automatic logic [1:0] gf22_mul(input logic [1:0] a, input logic [1:0] b);
        logic hh;
        hh = a[1] & b[1];
        return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
    endfunction

    // GF(2^2) multiply by phi = x
    function automatic logic [1:0] gf22_mul_phi(input logic [1:0] a);
        return {a[1] ^ a[0], a[1]};
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh, hl, lh, ll;
        hh = gf22_mul(a[3:2], b[3:2]);
        hl = gf22_mul(a[3:2], b[1:0]);
        lh = gf22_mul(a[1:0], b[3:2]);
        ll = gf22_mul(a[1:0], b[1:0]);
        return {hh ^ hl ^ lh, gf22_mul_phi(hh) ^ ll};
    endfunction

    function automatic logic [3:0] gf4_sq(input logic [3:0] a);
        return {a[3], a[3] ^ a[2], a[2] ^ a[1], a[3] ^ a[1] ^ a[0]};
    endfunction

    // Multiply by lambda; equivalent to gf4_mul(a, GF4_LAMBDA) but pure XORs
    function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] a);
        return {a[2] ^ a[0], a[3] ^ a[2] ^ a[1] ^ a[0], a[3], a[2]};
    endfunction

    // a^-1 = a^14 = a^2 * a^4 * a^8 in a group of order 15; 0 maps to 0
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf4_sq(a);
        a4 = gf4_sq(a2);
        a8 = gf4_sq(a4);
        return gf4_mul(gf4_mul(a2, a4), a8);
    endfunction

    // Output affine step of the forward S-box
    function automatic logic [7:0] sbox_fwd_affine(input logic [7:0] x);
        return gf2_mat_mul(AFFINE_MAT, x) ^ AFFINE_C;
    endfunction

endpackage

// File: rtl/inv_affine_iso_map.sv
// -----------------------------------------------------------------------------
// inv_affine_iso_map
// Combinational front end of the inverse S-box: removes the affine constant,
// applies the inverse affine matrix and maps the result into the composite
// field representation.
//   i_byte : ciphertext-domain byte
//   o_iso  : composite-field element {high nibble, low nibble}
// -----------------------------------------------------------------------------
module inv_affine_iso_map (
    input  logic [7:0] i_byte,
    output logic [7:0] o_iso
);
    import aes_pkg::*;

    logic [7:0] w_unmasked;
    logic [7:0] w_pre;

    assign w_unmasked = i_byte ^ AFFINE_C;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign w_pre[gi] = ^(INV_AFFINE_MAT[gi] & w_unmasked);
            assign o_iso[gi] = ^(ISO_MAP[gi] & w_pre);
        end
    endgenerate

endmodule

// File: rtl/inv_sbox.sv
// -----------------------------------------------------------------------------
// inv_sbox
// Pipelined AES inverse S-box using composite-field inversion.
// Parameter OUT_REG: 1 = output register stage (latency 6), 0 = none (latency 5)
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_byte valid
//   in_ready  : pipeline advances this cycle (input accepted if in_valid)
//   in_byte   : input byte
//   out_valid : out_byte valid
//   out_ready : downstream accepts out_byte
//   out_byte  : InvSbox(in_byte)
// The whole pipeline moves in lockstep on a single advance signal, so a stalled
// output freezes every stage and no beat is lost or duplicated.
// -----------------------------------------------------------------------------
module inv_sbox #(
    parameter int OUT_REG = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte
);
    import aes_pkg::*;

    logic       w_adv;
    logic [7:0] w_iso;

    // S0: composite element split as high, low and high^low
    logic       r_s0_v;
    logic [3:0] r_s0_hi, r_s0_lo, r_s0_hx;
    // S1: d = lambda*high^2 ^ (high^low)*low
    logic       r_s1_v;
    logic [3:0] r_s1_d, r_s1_hi, r_s1_hx;
    // S2: d^-1
    logic       r_s2_v;
    logic [3:0] r_s2_dinv, r_s2_hi, r_s2_hx;
    // S3: inverse nibbles
    logic       r_s3_v;
    logic [3:0] r_s3_oh, r_s3_ol;
    // S4: back in the polynomial basis
    logic       r_s4_v;
    logic [7:0] r_s4_byte;

    inv_affine_iso_map u_map (
        .i_byte (in_byte),
        .o_iso  (w_iso)
    );

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_v    <= 1'b0;
            r_s0_hi   <= '0;
            r_s0_lo   <= '0;
            r_s0_hx   <= '0;
            r_s1_v    <= 1'b0;
            r_s1_d    <= '0;
            r_s1_hi   <= '0;
            r_s1_hx   <= '0;
            r_s2_v    <= 1'b0;
            r_s2_dinv <= '0;
            r_s2_hi   <= '0;
            r_s2_hx   <= '0;
            r_s3_v    <= 1'b0;
            r_s3_oh   <= '0;
            r_s3_ol   <= '0;
            r_s4_v    <= 1'b0;
            r_s4_byte <= '0;
        end else if (w_adv) begin
            r_s0_v    <= in_valid;
            r_s0_hi   <= w_iso[7:4];
            r_s0_lo   <= w_iso[3:0];
            r_s0_hx   <= w_iso[7:4] ^ w_iso[3:0];

            r_s1_v    <= r_s0_v;
            r_s1_d    <= gf4_mul_lambda(gf4_sq(r_s0_hi)) ^ gf4_mul(r_s0_hx, r_s0_lo);
            r_s1_hi   <= r_s0_hi;
            r_s1_hx   <= r_s0_hx;

            // d = 0 only for the zero element; gf4_inv(0) = 0 carries it to 0x00
            r_s2_v    <= r_s1_v;
            r_s2_dinv <= gf4_inv(r_s1_d);
            r_s2_hi   <= r_s1_hi;
            r_s2_hx   <= r_s1_hx;

            r_s3_v    <= r_s2_v;
            r_s3_oh   <= gf4_mul(r_s2_hi, r_s2_dinv);
            r_s3_ol   <= gf4_mul(r_s2_hx, r_s2_dinv);

            r_s4_v    <= r_s3_v;
            r_s4_byte <= gf2_mat_mul(INV_ISO_MAP, {r_s3_oh, r_s3_ol});
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic       r_s5_v;
            logic [7:0] r_s5_byte;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s5_v    <= 1'b0;
                    r_s5_byte <= '0;
                end else if (w_adv) begin
                    r_s5_v    <= r_s4_v;
                    r_s5_byte <= r_s4_byte;
                end
            end

            assign out_valid = r_s5_v;
            assign out_byte  = r_s5_byte;
        end else begin : g_no_out_reg
            assign out_valid = r_s4_v;
            assign out_byte  = r_s4_byte;
        end
    endgenerate

endmodule

// File: tb/tb_inv_sbox.sv
// -----------------------------------------------------------------------------
// tb_inv_sbox
// Self-checking bench for inv_sbox (OUT_REG=1 instance plus an OUT_REG=0
// instance). The reference S-box tables are built from plain GF(2^8)
// arithmetic modulo x^8+x^4+x^3+x+1. Inputs are driven at the falling edge,
// outputs sampled 1 ns later; "cycle n" of a test is the n-th falling edge.
// -----------------------------------------------------------------------------
module tb_inv_sbox;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_byte, out_byte;
    logic       in_valid_z, in_ready_z, out_valid_z, out_ready_z;
    logic [7:0] in_byte_z, out_byte_z;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    inv_sbox #(.OUT_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte)
    );

    inv_sbox #(.OUT_REG(0)) dut_z (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_z),
        .in_ready  (in_ready_z),
        .in_byte   (in_byte_z),
        .out_valid (out_valid_z),
        .out_ready (out_ready_z),
        .out_byte  (out_byte_z)
    );

    initial forever #5 clk = ~clk;

    // ---------------- reference GF(2^8) model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        if (a != 8'h00) begin
            for (int b = 1; b < 256; b++) begin
                if (gmul(a, 8'(b)) == 8'h01) r = 8'(b);
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] s, r, t;
        s = ginv(x);
        r = s ^ 8'h63;
        for (int k = 1; k <= 4; k++) begin
            t = (s << k) | (s >> (8 - k));
            r = r ^ t;
        end
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            in_valid_z = 1'b0; out_ready_z = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(negedge clk);
            rst = (cyc < 3);
            in_valid = (cyc < 3); in_byte = 8'($urandom);
            in_valid_z = (cyc < 3); in_byte_z = 8'($urandom);
            out_ready = 1'b0; out_ready_z = 1'b0;
            #1;
            if (cyc >= 1) begin
                checks++;
                if (out_valid !== 1'b0 || out_valid_z !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_valid cyc=%0d got=%b/%b exp=0/0", cyc, out_valid, out_valid_z);
                end
            end
            if (cyc >= 1 && cyc <= 3) begin
                checks++;
                if (out_byte !== 8'h00 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_state cyc=%0d byte=%h ready=%b exp byte=00 ready=1", cyc, out_byte, in_ready);
                end
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_vectors();
        logic [7:0] vin  [5];
        logic [7:0] vout [5];
        vin  = '{8'h63, 8'h7C, 8'hED, 8'h16, 8'hFE};
        vout = '{8'h00, 8'h01, 8'h53, 8'hFF, 8'h0C};
        for (int cyc = 0; cyc < 13; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 5); in_byte = vin[cyc % 5]; out_ready = 1'b1;
            #1;
            checks++;
            if (out_valid !== (cyc >= 6 && cyc <= 10)) begin
                errors++;
                $display("FAIL vec_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (cyc >= 6 && cyc <= 10));
            end
            if (cyc >= 6 && cyc <= 10) begin
                checks++;
                if (out_byte !== vout[cyc - 6]) begin
                    errors++;
                    $display("FAIL vec_byte cyc=%0d got=%h exp=%h", cyc, out_byte, vout[cyc - 6]);
                end
            end
        end
        $display("test_vectors done");
    endtask

    task automatic test_exhaustive();
        int nvalid;
        logic exp_v;
        nvalid = 0;
        for (int cyc = 0; cyc < 266; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 256); in_byte = fwd_tab[cyc % 256]; out_ready = 1'b1;
            #1;
            exp_v = (cyc >= 6 && cyc < 262);
            if (out_valid === 1'b1) nvalid++;
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL exh_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_byte !== 8'(cyc - 6)) begin
                    errors++;
                    $display("FAIL exh_byte cyc=%0d got=%h exp=%h", cyc, out_byte, 8'(cyc - 6));
                end
            end
        end
        checks++;
        if (nvalid != 256) begin
            errors++;
            $display("FAIL exh_count got=%0d exp=256", nvalid);
        end
        $display("test_exhaustive done valid_outputs=%0d", nvalid);
    endtask

    task automatic test_backpressure();
        logic [7:0] vin [3];
        logic [7:0] vexp [3];
        logic [7:0] got [$];
        vin  = '{8'h7C, 8'hED, 8'h16};
        vexp = '{8'h01, 8'h53, 8'hFF};
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 3); in_byte = vin[cyc % 3];
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (cyc >= 6 && cyc <= 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_byte !== 8'h01 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold cyc=%0d valid=%b byte=%h ready=%b exp 1/01/0", cyc, out_valid, out_byte, in_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready) got.push_back(out_byte);
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== vexp[i]) begin
                errors++;
                $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], vexp[i]);
            end
        end
        $display("test_backpressure done transfers=%0d", got.size());
    endtask

    task automatic test_bubble();
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            in_valid = (cyc == 0 || cyc == 2);
            in_byte = (cyc == 0) ? 8'hED : 8'h16;
            out_ready = 1'b1;
            #1;
            if (cyc >= 6) begin
                checks++;
                if (out_valid !== (cyc == 6 || cyc == 8)) begin
                    errors++;
                    $display("FAIL bub_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (cyc == 6 || cyc == 8));
                end
            end
            if (cyc == 6 || cyc == 8) begin
                checks++;
                if (out_byte !== ((cyc == 6) ? 8'h53 : 8'hFF)) begin
                    errors++;
                    $display("FAIL bub_byte cyc=%0d got=%h exp=%h", cyc, out_byte, (cyc == 6) ? 8'h53 : 8'hFF);
                end
            end
        end
        $display("test_bubble done");
    endtask

    task automatic test_reset_midstream();
        for (int cyc = 0; cyc < 13; cyc++) begin
            @(negedge clk);
            rst = (cyc == 3);
            in_valid = (cyc <= 4);
            case (cyc)
                0: in_byte = 8'h7C;
                1: in_byte = 8'hED;
                2: in_byte = 8'h16;
                3: in_byte = 8'h7C;
                default: in_byte = 8'h63;
            endcase
            out_ready = 1'b1;
            #1;
            if (cyc >= 3) begin
                checks++;
                if (out_valid !== (cyc == 10)) begin
                    errors++;
                    $display("FAIL mrst_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (cyc == 10));
                end
            end
            if (cyc == 3) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL mrst_ready cyc=%0d got=%b exp=1", cyc, in_ready);
                end
            end
            if (cyc == 4 || cyc == 10) begin
                checks++;
                if (out_byte !== 8'h00) begin
                    errors++;
                    $display("FAIL mrst_byte cyc=%0d got=%h exp=00", cyc, out_byte);
                end
            end
        end
        $display("test_reset_midstream done");
    endtask

    task automatic test_out_reg0();
        logic [7:0] vin [3];
        logic [7:0] vexp [3];
        vin  = '{8'h7C, 8'hED, 8'h16};
        vexp = '{8'h01, 8'h53, 8'hFF};
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            in_valid_z = (cyc < 3); in_byte_z = vin[cyc % 3]; out_ready_z = 1'b1;
            #1;
            checks++;
            if (out_valid_z !== (cyc >= 5 && cyc <= 7)) begin
                errors++;
                $display("FAIL or0_valid cyc=%0d got=%b exp=%b", cyc, out_valid_z, (cyc >= 5 && cyc <= 7));
            end
            if (cyc >= 5 && cyc <= 7) begin
                checks++;
                if (out_byte_z !== vexp[cyc - 5]) begin
                    errors++;
                    $display("FAIL or0_byte cyc=%0d got=%h exp=%h", cyc, out_byte_z, vexp[cyc - 5]);
                end
            end
        end
        $display("test_out_reg0 done");
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic       prev_stall;
        logic [7:0] prev_byte;
        logic [7:0] exp;
        int         nout;
        prev_stall = 1'b0; prev_byte = 8'h00; nout = 0;
        for (int cyc = 0; cyc < 560; cyc++) begin
            @(negedge clk);
            if (cyc < 500) begin
                in_valid  = ($urandom_range(3) != 0);
                in_byte   = 8'($urandom);
                out_ready = ($urandom_range(3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (!out_valid || out_ready));
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_byte !== prev_byte) begin
                    errors++;
                    $display("FAIL rnd_stable cyc=%0d valid=%b byte=%h exp 1/%h", cyc, out_valid, out_byte, prev_byte);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                nout++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra cyc=%0d got=%h exp=no_output", cyc, out_byte);
                end else begin
                    exp = q.pop_front();
                    if (out_byte !== exp) begin
                        errors++;
                        $display("FAIL rnd_byte cyc=%0d got=%h exp=%h", cyc, out_byte, exp);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) q.push_back(inv_tab[in_byte]);
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_byte  = out_byte;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_left got=%0d exp=0", q.size());
        end
        $display("test_random done outputs=%0d", nout);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
        in_valid_z = 1'b0; in_byte_z = 8'h00; out_ready_z = 1'b1;
        for (int i = 0; i < 256; i++) begin
            fwd_tab[i] = sbox_ref(8'(i));
            inv_tab[fwd_tab[i]] = 8'(i);
        end

        test_reset();
        idle(4);
        test_vectors();
        idle(8);
        test_exhaustive();
        idle(8);
        test_backpressure();
        idle(8);
        test_bubble();
        idle(8);
        test_reset_midstream();
        idle(8);
        test_out_reg0();
        idle(8);
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
